weight_loader: RTL and testbench

//   Upstream feeder for the 54-entry weight RAM (3x3x3 conv + 3x3x3 connect, 8b each).

---
 rtl/weight_loader_pkg.sv | 14 +
 rtl/weight_loader.sv | 96 +++++++++
 tb/tb_weight_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// Shared constants and state encoding for the weight RAM loader.
// The weight RAM and the conv datapath import the same depth and width.
package weight_loader_pkg;

  localparam int WL_NUM_WEIGHTS = 54;
  localparam int WL_DW          = 8;
  localparam int WL_AW          = $clog2(WL_NUM_WEIGHTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } wl_state_e;

endpackage

// File: rtl/weight_loader.sv
// Streams NUM_WEIGHTS bytes into the weight RAM write port after a start pulse,
// optionally verifies a trailing 8-bit checksum, then reports done/err.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready is a pure decode of the state register (high in LOAD), so it never
// depends combinationally on in_valid; in_data must be stable while in_valid is high.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int NUM_WEIGHTS = WL_NUM_WEIGHTS,
  parameter int DW          = WL_DW,
  parameter bit CHK_EN      = 1'b1,
  localparam int AW         = $clog2(NUM_WEIGHTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          weights_valid,
  output wl_state_e     state_dbg
);

  localparam logic [AW:0] CNT_MAX  = (AW+1)'(NUM_WEIGHTS);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(NUM_WEIGHTS - 1);

  wl_state_e     state;
  logic [AW:0]   cnt;
  logic [DW-1:0] sum;

  assign in_ready  = (state == ST_LOAD);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sum           <= '0;
      wen           <= 1'b0;
      waddr         <= '0;
      din           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      weights_valid <= 1'b0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_LOAD;
            busy          <= 1'b1;
            cnt           <= '0;
            sum           <= '0;
            weights_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt < CNT_MAX) begin
              wen   <= 1'b1;
              waddr <= cnt[AW-1:0];
              din   <= in_data;
              sum   <= sum + in_data;
              cnt   <= cnt + 1'b1;
              // Without a checksum the last weight closes the load alongside its write.
              if (!CHK_EN && cnt == CNT_LAST) begin
                state         <= ST_IDLE;
                busy          <= 1'b0;
                done          <= 1'b1;
                weights_valid <= 1'b1;
              end
            end else begin
              state         <= ST_IDLE;
              busy          <= 1'b0;
              done          <= (in_data == sum);
              err           <= (in_data != sum);
              weights_valid <= (in_data == sum);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: one checksum-enabled and one checksum-less instance
// share the stimulus; a cycle reference model and a write scoreboard check both.
module tb_weight_loader;
  import weight_loader_pkg::*;

  localparam int N  = WL_NUM_WEIGHTS;
  localparam int AW = $clog2(N);
  localparam int DW = WL_DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  always #5 clk = ~clk;

  logic          rdy [2];
  logic          wen [2];
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] din [2];
  logic          busy [2];
  logic          done [2];
  logic          err [2];
  logic          wv [2];
  wl_state_e     st [2];

  weight_loader #(.CHK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .wen(wen[0]), .waddr(waddr[0]), .din(din[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .weights_valid(wv[0]), .state_dbg(st[0])
  );

  weight_loader #(.CHK_EN(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .wen(wen[1]), .waddr(waddr[1]), .din(din[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .weights_valid(wv[1]), .state_dbg(st[1])
  );

  // ---------------- checking ----------------
  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_ld [2];
  int            m_cnt [2];
  logic [DW-1:0] m_sum [2];
  bit            m_wv [2];
  bit            e_wen [2];
  bit            e_done [2];
  bit            e_err [2];
  logic [AW-1:0] e_waddr [2];
  logic [DW-1:0] e_din [2];
  int            n_writes [2];
  int            n_done [2];
  int            n_err [2];

  // Scoreboard for the checksum instance: bytes in the order they must hit RAM.
  logic [DW-1:0] exp_q [$];
  int            w_idx;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ld[k] = 0; m_cnt[k] = 0; m_sum[k] = '0; m_wv[k] = 0;
      e_wen[k] = 0; e_done[k] = 0; e_err[k] = 0; e_waddr[k] = '0; e_din[k] = '0;
    end
    exp_q.delete();
    w_idx = 0;
  endtask

  task automatic model_step(input int k);
    bit chk_en;
    chk_en = (k == 0);
    e_wen[k] = 0; e_done[k] = 0; e_err[k] = 0;
    if (!m_ld[k]) begin
      if (start) begin
        m_ld[k] = 1; m_cnt[k] = 0; m_sum[k] = '0; m_wv[k] = 0;
      end
    end else if (in_valid) begin
      if (m_cnt[k] < N) begin
        e_wen[k]   = 1;
        e_waddr[k] = AW'(m_cnt[k]);
        e_din[k]   = in_data;
        m_sum[k]   = DW'((int'(m_sum[k]) + int'(in_data)) % 256);
        m_cnt[k]++;
        if (!chk_en && m_cnt[k] == N) begin
          m_ld[k] = 0; e_done[k] = 1; m_wv[k] = 1;
        end
      end else begin
        m_ld[k]   = 0;
        e_done[k] = (in_data == m_sum[k]);
        e_err[k]  = (in_data != m_sum[k]);
        m_wv[k]   = e_done[k];
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("d%0d.in_ready", k), rdy[k], m_ld[k]);
        check($sformatf("d%0d.busy", k), busy[k], m_ld[k]);
        check($sformatf("d%0d.state", k), st[k], m_ld[k]);
        check($sformatf("d%0d.wen", k), wen[k], e_wen[k]);
        check($sformatf("d%0d.waddr", k), waddr[k], e_waddr[k]);
        check($sformatf("d%0d.din", k), din[k], e_din[k]);
        check($sformatf("d%0d.done", k), done[k], e_done[k]);
        check($sformatf("d%0d.err", k), err[k], e_err[k]);
        check($sformatf("d%0d.weights_valid", k), wv[k], m_wv[k]);
        n_writes[k] += int'(wen[k]);
        n_done[k]   += int'(done[k]);
        n_err[k]    += int'(err[k]);
      end
      if (wen[0]) begin
        if (exp_q.size() == 0) begin
          check("sb.unexpected_write", 1, 0);
        end else begin
          check("sb.write_data", din[0], exp_q.pop_front());
          check("sb.write_addr", waddr[0], w_idx);
          w_idx++;
        end
      end
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d.in_ready", k), rdy[k], 0);
      check($sformatf("rst%0d.wen", k), wen[k], 0);
      check($sformatf("rst%0d.waddr", k), waddr[k], 0);
      check($sformatf("rst%0d.din", k), din[k], 0);
      check($sformatf("rst%0d.busy", k), busy[k], 0);
      check($sformatf("rst%0d.done", k), done[k], 0);
      check($sformatf("rst%0d.err", k), err[k], 0);
      check($sformatf("rst%0d.weights_valid", k), wv[k], 0);
    end
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  // mode 0: back-to-back beats, 1: random idle gaps, 2: valid toggles every cycle
  task automatic send_byte(input logic [DW-1:0] b, input int mode, input bit pulse_start);
    bit ok;
    int idles;
    idles = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
    repeat (idles) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulse_start;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = rdy[0];
      tick();
      start = 1'b0;
    end
    if (!ok) check("handshake_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    if (mode == 2) tick();
  endtask

  task automatic run_load(input logic [DW-1:0] bytes [N], input logic [DW-1:0] chk,
                          input int mode, input int start_at, input int abort_at);
    int s;
    bit exp_ok;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(bytes[i]);
    exp_ok = (int'(chk) == s % 256);
    for (int k = 0; k < 2; k++) begin
      n_writes[k] = 0; n_done[k] = 0; n_err[k] = 0;
    end
    exp_q.delete();
    w_idx = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(bytes[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      send_byte(bytes[i], mode, i == start_at);
    end
    send_byte(chk, mode, 1'b0);
    repeat (3) tick();
    check("load.writes", n_writes[0], N);
    check("load.done_pulses", n_done[0], exp_ok);
    check("load.err_pulses", n_err[0], !exp_ok);
    check("load.weights_valid", wv[0], exp_ok);
    check("load.busy_after", busy[0], 0);
    check("load.sb_drained", exp_q.size(), 0);
    check("nochk.writes", n_writes[1], N);
    check("nochk.done_pulses", n_done[1], 1);
    check("nochk.err_pulses", n_err[1], 0);
    check("nochk.weights_valid", wv[1], 1);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] ramp [N];
  logic [DW-1:0] hi   [N];
  logic [DW-1:0] rnd  [N];

  initial begin
    int s;
    for (int i = 0; i < N; i++) begin
      ramp[i] = DW'(i + 1);
      hi[i]   = DW'(8'h80 + i);
    end
    model_reset();
    tick();
    do_reset();
    tick();

    // Ramp 1..54 with its correct checksum, then an async reset while weights are valid.
    run_load(ramp, 8'hCD, 0, -1, -1);
    do_reset();
    tick();

    // Same stream, wrong checksum: writes still happen, err pulses.
    run_load(ramp, 8'h00, 0, -1, -1);

    // Toggling valid; checksum derived from the byte sum.
    s = 0;
    for (int i = 0; i < N; i++) s += int'(hi[i]);
    run_load(hi, DW'(s % 256), 2, -1, -1);

    // Start during a load is ignored; a later reset aborts; a clean reload follows.
    run_load(ramp, 8'hCD, 0, 10, -1);
    run_load(ramp, 8'hCD, 0, -1, 20);
    tick();
    run_load(ramp, 8'hCD, 0, -1, -1);

    // Random bytes, random gaps, checksum correct or corrupted.
    for (int r = 0; r < 6; r++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        rnd[i] = DW'($urandom);
        s += int'(rnd[i]);
      end
      if ($urandom_range(0, 1) == 1)
        run_load(rnd, DW'(s % 256), 1, -1, -1);
      else
        run_load(rnd, DW'((s % 256) ^ int'($urandom_range(1, 255))), 1, -1, -1);
    end

    // Valid while idle must have no effect.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
